// File: rtl/mem_burst_initiator.sv
// Burst initiator for the single-port memory bank.
// Takes one burst command at a time and either streams write beats
// straight onto the memory port or issues reads and returns the data as
// a stream. The memory port is owned exclusively by this block.
module mem_burst_initiator #(
    parameter int AddrSize = 8,
    parameter int DataSize = 32,
    parameter int LenSize  = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Cmd_Valid,
    output logic                Cmd_Ready,
    input  logic                Cmd_R_W,
    input  logic [AddrSize-1:0] Cmd_Addr,
    input  logic [LenSize-1:0]  Cmd_Len,
    input  logic                Wr_Valid,
    output logic                Wr_Ready,
    input  logic [DataSize-1:0] Wr_Data,
    output logic                Rd_Valid,
    input  logic                Rd_Ready,
    output logic [DataSize-1:0] Rd_Data,
    output logic                Rd_Last,
    output logic                Busy,
    output logic                Done,
    output logic                Mem_Valid,
    output logic                Mem_R_W,
    output logic [AddrSize-1:0] Mem_Addr,
    output logic [DataSize-1:0] Mem_Din,
    input  logic [DataSize-1:0] Mem_Dout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    state_t              state;
    logic [AddrSize-1:0] cur_addr;
    logic [LenSize-1:0]  beats_left;
    logic                last_beat;

    assign last_beat = (beats_left == '0);

    // Burst sequencing: address/count bookkeeping and the one-cycle Done pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Cmd_Valid) begin
                        cur_addr   <= Cmd_Addr;
                        beats_left <= Cmd_Len;
                        state      <= Cmd_R_W ? WRITE : RD_ISSUE;
                    end
                end
                WRITE: begin
                    // Beat is written to memory on the same edge as the handshake.
                    if (Wr_Valid) begin
                        if (last_beat) begin
                            state <= IDLE;
                            Done  <= 1'b1;
                        end else begin
                            cur_addr   <= cur_addr + AddrSize'(1);
                            beats_left <= beats_left - LenSize'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    // Memory holds Dout until the next read, so stalling here is safe.
                    if (Rd_Ready) begin
                        if (last_beat) begin
                            state <= IDLE;
                            Done  <= 1'b1;
                        end else begin
                            cur_addr   <= cur_addr + AddrSize'(1);
                            beats_left <= beats_left - LenSize'(1);
                            state      <= RD_ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port decode from the current state; the write path passes straight through.
    always_comb begin
        Cmd_Ready = (state == IDLE);
        Busy      = (state != IDLE);
        Wr_Ready  = (state == WRITE);
        Rd_Valid  = (state == RD_DATA);
        Rd_Last   = (state == RD_DATA) && last_beat;
        Rd_Data   = (state == RD_DATA) ? Mem_Dout : '0;
        Mem_Valid = ((state == WRITE) && Wr_Valid) || (state == RD_ISSUE);
        Mem_R_W   = (state == WRITE);
        Mem_Addr  = cur_addr;
        Mem_Din   = (state == WRITE) ? Wr_Data : '0;
    end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Bench for mem_burst_initiator: behavioural memory bank, scoreboard queues
// for expected memory writes and read beats, directed burst scenarios.
module tb_mem_burst_initiator;

    logic        Clk;
    logic        Reset;
    logic        Cmd_Valid, Cmd_Ready, Cmd_R_W;
    logic [7:0]  Cmd_Addr;
    logic [3:0]  Cmd_Len;
    logic        Wr_Valid, Wr_Ready;
    logic [31:0] Wr_Data;
    logic        Rd_Valid, Rd_Ready, Rd_Last;
    logic [31:0] Rd_Data;
    logic        Busy, Done;
    logic        Mem_Valid, Mem_R_W;
    logic [7:0]  Mem_Addr;
    logic [31:0] Mem_Din, Mem_Dout;

    mem_burst_initiator #(.AddrSize(8), .DataSize(32), .LenSize(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_R_W(Cmd_R_W),
        .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
        .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
        .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data), .Rd_Last(Rd_Last),
        .Busy(Busy), .Done(Done),
        .Mem_Valid(Mem_Valid), .Mem_R_W(Mem_R_W), .Mem_Addr(Mem_Addr),
        .Mem_Din(Mem_Din), .Mem_Dout(Mem_Dout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // memory bank model: write on Valid&R_W, Dout updates only on a read
    logic [31:0] mem [0:255];
    always @(posedge Clk) begin
        if (Mem_Valid) begin
            if (Mem_R_W) mem[Mem_Addr] <= Mem_Din;
            else         Mem_Dout      <= mem[Mem_Addr];
        end
    end

    typedef struct { logic [7:0] a; logic [31:0] d; } wr_exp_t;
    typedef struct { logic [31:0] d; logic last; } rd_exp_t;
    wr_exp_t wq[$];
    rd_exp_t rq[$];
    logic [31:0] ref_mem [0:255];

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0, acc_cnt = 0, done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard side: pop expectations whenever the DUT produces a beat
    always @(negedge Clk) begin
        if (Done) done_cnt++;
        if (Mem_Valid) acc_cnt++;
        if (Mem_Valid && Mem_R_W) begin
            wr_cnt++;
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                wr_exp_t e;
                e = wq.pop_front();
                chk("wr_addr", Mem_Addr, e.a);
                chk("wr_data", Mem_Din, e.d);
            end
        end
        if (Rd_Valid && Rd_Ready) begin
            if (rq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                rd_exp_t e;
                e = rq.pop_front();
                chk("rd_data", Rd_Data, e.d);
                chk("rd_last", Rd_Last, e.last);
            end
        end
    end

    task automatic wr_burst(input logic [7:0] a, input int len, input logic [31:0] base,
                            input int gap_after, input int gap_n);
        Cmd_Valid = 1; Cmd_R_W = 1; Cmd_Addr = a; Cmd_Len = 4'(len);
        @(negedge Clk); chk("wr_cmd_rdy", Cmd_Ready, 1);
        @(posedge Clk); #1;
        Cmd_Valid = 0;
        for (int i = 0; i <= len; i++) begin
            logic [7:0] ea;
            ea = 8'(a + i);
            Wr_Valid = 1; Wr_Data = base + 32'(i);
            wq.push_back('{ea, Wr_Data});
            ref_mem[ea] = Wr_Data;
            @(negedge Clk); chk("wr_ready", Wr_Ready, 1);
            @(posedge Clk); #1;
            Wr_Valid = 0;
            if (i == gap_after) begin
                repeat (gap_n) begin
                    @(negedge Clk);
                    chk("gap_mem_idle", Mem_Valid, 0);
                    chk("gap_busy", Busy, 1);
                    @(posedge Clk); #1;
                end
            end
        end
        @(negedge Clk); chk("wr_done", Done, 1); chk("wr_idle", Busy, 0);
        @(posedge Clk); #1;
    endtask

    task automatic rd_cmd(input logic [7:0] a, input int len, input bit hold);
        for (int i = 0; i <= len; i++) rq.push_back('{ref_mem[8'(a + i)], i == len});
        Cmd_Valid = 1; Cmd_R_W = 0; Cmd_Addr = a; Cmd_Len = 4'(len);
        @(negedge Clk); chk("rd_cmd_rdy", Cmd_Ready, 1);
        @(posedge Clk); #1;
        if (!hold) Cmd_Valid = 0;
    endtask

    task automatic rd_beats(input logic [7:0] a, input int len, input int sb, input int sn,
                            input bit hold);
        for (int i = 0; i <= len; i++) begin
            @(negedge Clk);
            chk("iss_valid", Mem_Valid, 1);
            chk("iss_rw", Mem_R_W, 0);
            chk("iss_addr", Mem_Addr, 8'(a + i));
            chk("iss_no_rd", Rd_Valid, 0);
            if (hold) chk("cmd_blocked", Cmd_Ready, 0);
            @(posedge Clk); #1;
            if (i == sb) begin
                Rd_Ready = 0;
                repeat (sn) begin
                    @(negedge Clk);
                    chk("stall_vld", Rd_Valid, 1);
                    chk("stall_mem", Mem_Valid, 0);
                    chk("stall_data", Rd_Data, ref_mem[8'(a + i)]);
                    @(posedge Clk); #1;
                end
                Rd_Ready = 1;
            end
            @(negedge Clk);
            chk("rd_vld", Rd_Valid, 1);
            if (hold) chk("cmd_blocked", Cmd_Ready, 0);
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        chk("rd_done", Done, 1); chk("rd_idle", Busy, 0); chk("rd_cmd_rdy_back", Cmd_Ready, 1);
        @(posedge Clk); #1;
    endtask

    initial begin
        int w0, d0, a0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        Reset = 0; Cmd_Valid = 0; Cmd_R_W = 0; Cmd_Addr = '0; Cmd_Len = '0;
        Wr_Valid = 0; Wr_Data = '0; Rd_Ready = 1;
        #23;
        chk("rst_cmd_rdy", Cmd_Ready, 1); chk("rst_wr_rdy", Wr_Ready, 0);
        chk("rst_rd_vld", Rd_Valid, 0);   chk("rst_rd_last", Rd_Last, 0);
        chk("rst_busy", Busy, 0);         chk("rst_done", Done, 0);
        chk("rst_mem_vld", Mem_Valid, 0); chk("rst_mem_rw", Mem_R_W, 0);
        chk("rst_mem_addr", Mem_Addr, 0); chk("rst_mem_din", Mem_Din, 0);
        chk("rst_rd_data", Rd_Data, 0);
        @(posedge Clk); #1; Reset = 1;
        @(posedge Clk); #1;

        // write 0x10 len 3 with a 2-cycle gap after beat 1
        w0 = wr_cnt; d0 = done_cnt;
        wr_burst(8'h10, 3, 32'hA000_00A0, 1, 2);
        chk("wr_count", wr_cnt - w0, 4);
        chk("wr_done_once", done_cnt - d0, 1);

        // streaming readback with Rd_Ready held high
        d0 = done_cnt;
        rd_cmd(8'h10, 3, 0); rd_beats(8'h10, 3, -1, 0, 0);
        chk("rd_done_once", done_cnt - d0, 1);

        // backpressure on beat 1 for 5 cycles
        rd_cmd(8'h10, 3, 0); rd_beats(8'h10, 3, 1, 5, 0);

        // address wrap at the top of the map, then readback
        wr_burst(8'hFE, 3, 32'h5EED_0000, -1, 0);
        rd_cmd(8'hFE, 3, 0); rd_beats(8'hFE, 3, -1, 0, 0);

        // reset while in RD_DATA abandons the burst
        d0 = done_cnt;
        rd_cmd(8'h10, 3, 0);
        @(negedge Clk);
        @(posedge Clk); #1; Rd_Ready = 0;
        @(negedge Clk); chk("pre_rst_rd_vld", Rd_Valid, 1);
        #2 Reset = 0;
        #1;
        chk("mid_rst_rd_vld", Rd_Valid, 0); chk("mid_rst_mem_vld", Mem_Valid, 0);
        chk("mid_rst_busy", Busy, 0);       chk("mid_rst_cmd_rdy", Cmd_Ready, 1);
        rq.delete();
        @(posedge Clk); #1; Reset = 1; Rd_Ready = 1;
        @(negedge Clk); chk("rst_no_done", done_cnt - d0, 0);
        @(posedge Clk); #1;
        rd_cmd(8'h10, 3, 0); rd_beats(8'h10, 3, -1, 0, 0);

        // Cmd_Valid held through a single-beat read
        a0 = acc_cnt; d0 = done_cnt;
        rd_cmd(8'h11, 0, 1);
        rd_beats(8'h11, 0, -1, 0, 1);
        chk("single_access", acc_cnt - a0, 1);
        rq.push_back('{ref_mem[8'h11], 1'b1});
        Cmd_Valid = 0;
        rd_beats(8'h11, 0, -1, 0, 0);
        chk("held_done_cnt", done_cnt - d0, 2);

        repeat (3) @(posedge Clk);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop if anything above ever stalls
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
